// File: rtl/decode_packet.sv
// decode_packet: reassembles five Aurora flits into one wide DFX word.
// Flits 0..3 each carry a 249-bit payload slice; flit 4 carries the 38-bit tail.
// The word is handed off on a valid/ready channel. The block stalls upstream
// until the consumer takes the word.
module decode_packet #(
    parameter int unsigned DATA_WIDTH        = 1024,
    parameter int unsigned ADDR_WIDTH        = 10,
    parameter int unsigned DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int unsigned NUMBER_PACKET     = 5,
    parameter int unsigned AURORA_DATA_WIDTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         decode_valid,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    output logic                         decode_ready,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic                         dfx_valid,
    input  logic                         dfx_ready,
    output logic [1:0]                   src_router_recv,
    output logic [1:0]                   ttl_recv,
    output logic                         decode_done,
    output logic                         seq_error
);

    // Flit header geometry: [1:0] src, [4:2] pkt number, [6:5] ttl, rest payload.
    localparam int unsigned HDR_W      = 7;
    localparam int unsigned PAYLOAD_W  = AURORA_DATA_WIDTH - HDR_W;
    localparam int unsigned FULL_FLITS = NUMBER_PACKET - 1;
    localparam int unsigned FULL_W     = FULL_FLITS * PAYLOAD_W;
    localparam int unsigned TAIL_W     = DATA_DFX_WIDTH - FULL_W;
    localparam int unsigned LAST_PKT   = NUMBER_PACKET - 1;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              exp_q, exp_d;
    logic [1:0]              src_q, src_d;
    logic [1:0]              ttl_q, ttl_d;
    logic [FULL_W-1:0]       word_q, word_d;
    logic [DATA_DFX_WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]              out_src_q, out_src_d;
    logic [1:0]              out_ttl_q, out_ttl_d;
    logic                    dfx_valid_q, dfx_valid_d;
    logic                    done_q, done_d;
    logic                    seq_err_q, seq_err_d;

    logic                    accept_c;
    logic                    frame_err_c;
    logic [1:0]              flit_src_c;
    logic [2:0]              flit_pkt_c;
    logic [1:0]              flit_ttl_c;
    logic [PAYLOAD_W-1:0]    flit_payload_c;

    // Header field split of the incoming flit.
    assign flit_src_c     = data_recv[1:0];
    assign flit_pkt_c     = data_recv[4:2];
    assign flit_ttl_c     = data_recv[6:5];
    assign flit_payload_c = data_recv[AURORA_DATA_WIDTH-1:HDR_W];

    // Upstream may push only while collecting.
    assign decode_ready = (state_q == COLLECT);
    assign accept_c     = decode_valid && decode_ready;

    // Out-of-order, out-of-range, or foreign-source flits break the frame.
    assign frame_err_c = (flit_pkt_c != exp_q)
                      || (flit_pkt_c > 3'(LAST_PKT))
                      || ((flit_pkt_c != 3'd0) && (flit_src_c != src_q));

    assign data_dfx_recv   = out_data_q;
    assign src_router_recv = out_src_q;
    assign ttl_recv        = out_ttl_q;
    assign dfx_valid       = dfx_valid_q;
    assign decode_done     = done_q;
    assign seq_error       = seq_err_q;

    // Next-state, assembly buffer and handoff register updates.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        src_d       = src_q;
        ttl_d       = ttl_q;
        word_d      = word_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_ttl_d   = out_ttl_q;
        dfx_valid_d = dfx_valid_q;
        done_d      = 1'b0;
        seq_err_d   = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    if (frame_err_c) begin
                        // Drop the partial word; a flit 0 restarts assembly on the spot.
                        seq_err_d = 1'b1;
                        word_d    = '0;
                        exp_d     = 3'd0;
                        if (flit_pkt_c == 3'd0) begin
                            word_d[PAYLOAD_W-1:0] = flit_payload_c;
                            src_d                 = flit_src_c;
                            ttl_d                 = flit_ttl_c;
                            exp_d                 = 3'd1;
                        end
                    end else if (flit_pkt_c == 3'd0) begin
                        // Fresh word: clear stale bits and capture the header.
                        word_d                = '0;
                        word_d[PAYLOAD_W-1:0] = flit_payload_c;
                        src_d                 = flit_src_c;
                        ttl_d                 = flit_ttl_c;
                        exp_d                 = 3'd1;
                    end else if (flit_pkt_c == 3'(LAST_PKT)) begin
                        // Last flit: only its low tail bits are meaningful.
                        out_data_d  = {data_recv[HDR_W +: TAIL_W], word_q};
                        out_src_d   = src_q;
                        out_ttl_d   = ttl_q;
                        dfx_valid_d = 1'b1;
                        exp_d       = 3'd0;
                        state_d     = OUTPUT;
                    end else begin
                        for (int unsigned k = 1; k < FULL_FLITS; k++) begin
                            if (flit_pkt_c == 3'(k)) begin
                                word_d[k*PAYLOAD_W +: PAYLOAD_W] = flit_payload_c;
                            end
                        end
                        exp_d = exp_q + 3'd1;
                    end
                end
            end
            OUTPUT: begin
                if (dfx_valid_q && dfx_ready) begin
                    dfx_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = COLLECT;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            exp_q       <= 3'd0;
            src_q       <= 2'd0;
            ttl_q       <= 2'd0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_src_q   <= 2'd0;
            out_ttl_q   <= 2'd0;
            dfx_valid_q <= 1'b0;
            done_q      <= 1'b0;
            seq_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            src_q       <= src_d;
            ttl_q       <= ttl_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_ttl_q   <= out_ttl_d;
            dfx_valid_q <= dfx_valid_d;
            done_q      <= done_d;
            seq_err_q   <= seq_err_d;
        end
    end

endmodule

// File: tb/tb_decode_packet.sv
// tb_decode_packet: directed scoreboard bench for decode_packet.
module tb_decode_packet;

    localparam int unsigned DW = 1034;

    logic          clk;
    logic          rst_n;
    logic          decode_valid;
    logic [255:0]  data_recv;
    logic          decode_ready;
    logic [DW-1:0] data_dfx_recv;
    logic          dfx_valid;
    logic          dfx_ready;
    logic [1:0]    src_router_recv;
    logic [1:0]    ttl_recv;
    logic          decode_done;
    logic          seq_error;

    typedef struct {
        logic [DW-1:0] word;
        logic [1:0]    src;
        logic [1:0]    ttl;
    } item_t;

    item_t sb[$];
    int    checks;
    int    errors;
    int    seq_cnt;
    int    done_cnt;

    decode_packet dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .decode_valid    (decode_valid),
        .data_recv       (data_recv),
        .decode_ready    (decode_ready),
        .data_dfx_recv   (data_dfx_recv),
        .dfx_valid       (dfx_valid),
        .dfx_ready       (dfx_ready),
        .src_router_recv (src_router_recv),
        .ttl_recv        (ttl_recv),
        .decode_done     (decode_done),
        .seq_error       (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (seq_error === 1'b1) seq_cnt++;
        if (decode_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_flit(input logic [7:0] fill, input logic [1:0] ttl,
                                             input logic [2:0] pkt, input logic [1:0] src);
        logic [255:0] f;
        f      = {32{fill}};
        f[6:0] = {ttl, pkt, src};
        return f;
    endfunction

    function automatic item_t mk_item(input logic [1:0] src, input logic [1:0] ttl, input logic [7:0] base);
        item_t        it;
        logic [255:0] f;
        it.word = '0;
        for (int k = 0; k < 4; k++) begin
            f = mk_flit(base + 8'(k), ttl, 3'(k), src);
            it.word[k*249 +: 249] = f[255:7];
        end
        f = mk_flit(base + 8'd4, ttl, 3'd4, src);
        it.word[996 +: 38] = f[44:7];
        it.src = src;
        it.ttl = ttl;
        return it;
    endfunction

    // Present one flit and wait (bounded) for the edge that accepts it.
    task automatic send(input logic [2:0] pkt, input logic [1:0] src, input logic [1:0] ttl,
                        input logic [7:0] fill);
        int n;
        @(negedge clk);
        decode_valid = 1'b1;
        data_recv    = mk_flit(fill, ttl, pkt, src);
        n = 0;
        while (!decode_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 256'(decode_ready), 256'(1));
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        decode_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [1:0] src, input logic [1:0] ttl, input logic [7:0] base);
        sb.push_back(mk_item(src, ttl, base));
        for (int k = 0; k < 5; k++) send(3'(k), src, ttl, base + 8'(k));
    endtask

    task automatic cmp_item(input item_t it);
        for (int i = 0; i < 5; i++)
            chk($sformatf("word_chunk%0d", i), 256'(data_dfx_recv >> (i*256)), 256'(it.word >> (i*256)));
        chk("src_router_recv", 256'(src_router_recv), 256'(it.src));
        chk("ttl_recv", 256'(ttl_recv), 256'(it.ttl));
    endtask

    task automatic pop_item(output item_t it);
        chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
        if (sb.size() != 0) it = sb.pop_front();
        else it = mk_item(2'd0, 2'd0, 8'd0);
    endtask

    // Called right after the flit-4 accept edge, with dfx_ready already 1.
    task automatic check_word();
        item_t it;
        @(negedge clk);
        decode_valid = 1'b0;
        chk("dfx_valid_rise", 256'(dfx_valid), 256'(1));
        chk("ready_low_output", 256'(decode_ready), 256'(0));
        pop_item(it);
        cmp_item(it);
        @(negedge clk);
        chk("done_pulse", 256'(decode_done), 256'(1));
        chk("dfx_valid_clear", 256'(dfx_valid), 256'(0));
        chk("ready_back", 256'(decode_ready), 256'(1));
    endtask

    initial begin
        item_t it;
        int    s0;
        int    d0;
        checks = 0; errors = 0; seq_cnt = 0; done_cnt = 0;
        rst_n = 1'b0; decode_valid = 1'b0; data_recv = '0; dfx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dfx_valid", 256'(dfx_valid), 256'(0));
        chk("rst_done", 256'(decode_done), 256'(0));
        chk("rst_seq_error", 256'(seq_error), 256'(0));
        chk("rst_data", 256'(data_dfx_recv), 256'(0));
        chk("rst_src", 256'(src_router_recv), 256'(0));
        chk("rst_ttl", 256'(ttl_recv), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 256'(decode_ready), 256'(1));

        // Back-to-back clean word, consumer always ready.
        send_seq(2'd0, 2'd2, 8'h10);
        check_word();

        // Consumer stalls 10 cycles while the next flit 0 waits upstream.
        dfx_ready = 1'b0;
        send_seq(2'd1, 2'd3, 8'h20);
        @(negedge clk);
        it = mk_item(2'd2, 2'd1, 8'h40);
        sb.push_back(it);
        decode_valid = 1'b1;
        data_recv    = mk_flit(8'h40, 2'd1, 3'd0, 2'd2);
        chk("stall_valid_rise", 256'(dfx_valid), 256'(1));
        pop_item(it);
        cmp_item(it);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_ready_low", 256'(decode_ready), 256'(0));
            chk("stall_valid_held", 256'(dfx_valid), 256'(1));
            cmp_item(it);
        end
        dfx_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_pulse", 256'(decode_done), 256'(1));
        chk("stall_ready_back", 256'(decode_ready), 256'(1));
        for (int k = 1; k < 5; k++) send(3'(k), 2'd2, 2'd1, 8'h40 + 8'(k));
        check_word();

        // Skipped flit 3, then a clean recovery word.
        s0 = seq_cnt;
        send(3'd0, 2'd0, 2'd1, 8'h50);
        send(3'd1, 2'd0, 2'd1, 8'h51);
        send(3'd3, 2'd0, 2'd1, 8'h53);
        idle();
        @(negedge clk);
        chk("skip_seq_error", 256'(seq_cnt - s0), 256'(1));
        chk("skip_no_valid", 256'(dfx_valid), 256'(0));
        send_seq(2'd3, 2'd0, 8'h60);
        check_word();

        // Restart on a second flit 0: word built from the restart onward.
        s0 = seq_cnt;
        send(3'd0, 2'd1, 2'd2, 8'hE0);
        send(3'd1, 2'd1, 2'd2, 8'hE1);
        send_seq(2'd1, 2'd2, 8'h70);
        check_word();
        @(negedge clk);
        chk("restart_seq_error", 256'(seq_cnt - s0), 256'(1));

        // Source router change mid-word.
        s0 = seq_cnt;
        send(3'd0, 2'd0, 2'd2, 8'h80);
        send(3'd1, 2'd0, 2'd2, 8'h81);
        send(3'd2, 2'd1, 2'd2, 8'h82);
        idle();
        @(negedge clk);
        chk("src_seq_error", 256'(seq_cnt - s0), 256'(1));
        chk("src_no_valid", 256'(dfx_valid), 256'(0));

        // Reset in the middle of assembly.
        s0 = seq_cnt;
        d0 = done_cnt;
        send(3'd0, 2'd2, 2'd3, 8'h90);
        send(3'd1, 2'd2, 2'd3, 8'h91);
        send(3'd2, 2'd2, 2'd3, 8'h92);
        @(negedge clk);
        decode_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 256'(data_dfx_recv), 256'(0));
        chk("mid_rst_src", 256'(src_router_recv), 256'(0));
        chk("mid_rst_ttl", 256'(ttl_recv), 256'(0));
        chk("mid_rst_valid", 256'(dfx_valid), 256'(0));
        chk("mid_rst_ready", 256'(decode_ready), 256'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_err", 256'(seq_cnt - s0), 256'(0));
        chk("mid_rst_no_done", 256'(done_cnt - d0), 256'(0));
        send_seq(2'd2, 2'd1, 8'hA0);
        check_word();

        repeat (2) @(negedge clk);
        chk("total_done", 256'(done_cnt), 256'(6));
        chk("total_seq_error", 256'(seq_cnt), 256'(3));
        chk("sb_drained", 256'(sb.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/decode_packet.md
DECODE_PACKET -- requirements
Module: decode_packet

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1024, the payload data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, the address field width.
REQ-003 SHALL have parameter DATA_DFX_WIDTH, default DATA_WIDTH+ADDR_WIDTH (1034), the width of the reassembled word.
REQ-004 SHALL have parameter NUMBER_PACKET, default 5, the number of flits per word.
REQ-005 SHALL have parameter AURORA_DATA_WIDTH, default 256, the flit width.
REQ-006 SHALL use one clock and an asynchronous, active-low reset: port clk (input, 1), the rising-edge clock.
REQ-007 SHALL have port rst_n (input, 1), the asynchronous active-low reset.
REQ-008 SHALL have port decode_valid (input, 1), asserted when the fifo-out flit is valid.
REQ-009 SHALL have port data_recv (input, AURORA_DATA_WIDTH), the flit.
REQ-010 SHALL have port decode_ready (output, 1), asserted when the block accepts a flit.
REQ-011 SHALL have port data_dfx_recv (output, DATA_DFX_WIDTH), the reassembled word.
REQ-012 SHALL have port dfx_valid (output, 1), asserted when data_dfx_recv is valid.
REQ-013 SHALL have port dfx_ready (input, 1), asserted when the consumer accepts the word.
REQ-014 SHALL have port src_router_recv (output, 2), the source router captured from flit 0.
REQ-015 SHALL have port ttl_recv (output, 2), the TTL captured from flit 0.
REQ-016 SHALL have port decode_done (output, 1), a one-cycle pulse on word handoff.
REQ-017 SHALL have port seq_error (output, 1), a one-cycle pulse on a framing error.

Function
REQ-018 SHALL decode the flit format as: [1:0] src_router, [4:2] pkt_number, [6:5] TTL, [255:7] payload.
REQ-019 SHALL write the payload of flits 0..3 (249 bits each) into word bits [k*249 +: 249], where k = pkt_number.
REQ-020 SHALL write flit 4 bits [44:7] into word bits [1033:996], and SHALL ignore flit 4 bits [255:45].
REQ-021 SHALL implement two states, COLLECT and OUTPUT; decode_ready SHALL be 1 exactly when the state is COLLECT (combinational decode of the state register).
REQ-022 SHALL count a flit as accepted on a rising clk edge where decode_valid=1 and decode_ready=1.
REQ-023 SHALL track an expected-number counter (3 bits) that starts at 0, increments per in-order flit, and clears to 0 on completion.
REQ-024 SHALL, on acceptance of flit 0, capture src_router and TTL into internal registers.
REQ-025 SHALL treat as a framing error any accepted flit whose pkt_number != expected, whose pkt_number > 4, or (for flits 1..4) whose src_router differs from the captured value.
REQ-026 SHALL, on a framing error: pulse seq_error for 1 cycle, discard the partial word, and set expected to 0.
REQ-027 SHALL, if the erroring flit has pkt_number==0, restart assembly with that flit (capture it, set expected to 1).
REQ-028 SHALL, on acceptance of an in-order flit 4, load data_dfx_recv, src_router_recv and ttl_recv, set dfx_valid=1 in the next cycle, and move to OUTPUT.
REQ-029 SHALL hold data_dfx_recv, src_router_recv, ttl_recv and dfx_valid stable in OUTPUT until dfx_valid&&dfx_ready.
REQ-030 SHALL, on the edge where dfx_valid&&dfx_ready: clear dfx_valid, pulse decode_done for 1 cycle, and return to COLLECT, so that decode_ready=1 in the following cycle.
REQ-031 SHALL apply backpressure in OUTPUT (decode_ready=0); flits are not consumed, and an upstream fifo holds them.
REQ-032 SHALL keep dfx_ready without effect while in COLLECT.
REQ-033 SHALL keep the minimum period at 6 cycles per word: 5 accept cycles plus 1 handoff cycle with dfx_ready tied 1.
REQ-034 SHALL clear unwritten word bits on each new flit 0, so no stale bits persist.

Reset
REQ-035 SHALL, on rst_n=0 (asynchronous), enter state COLLECT with expected=0.
REQ-036 SHALL, on reset, set dfx_valid, decode_done and seq_error to 0.
REQ-037 SHALL, on reset, set data_dfx_recv, src_router_recv and ttl_recv to 0.
REQ-038 SHALL, on reset, set decode_ready to 1 in the first cycle after deassertion.
REQ-039 SHALL, on reset mid-assembly or in OUTPUT, lose the partial or held word, with no decode_done or seq_error pulse.

Verification
REQ-040 SHALL cover back-to-back flits 0..4 (payload = flit index replicated, TTL=2, src=0) with dfx_ready=1 -> dfx_valid one cycle after flit 4, word bits [248:0]=flit0 payload and [1033:996]=flit4 [44:7], ttl_recv=2, src_router_recv=0, decode_done pulse.
REQ-041 SHALL cover dfx_ready=0 for 10 cycles after completion -> decode_ready=0, word stable, and the next flit 0 held in the fifo is accepted only after the handshake.
REQ-042 SHALL cover flits 0,1,3 -> seq_error pulse at flit 3, expected=0, and a subsequent clean sequence 0..4 producing a correct word.
REQ-043 SHALL cover flits 0,1,0,1,2,3,4 -> one seq_error pulse, and the word built from the second flit-0 onward.
REQ-044 SHALL cover a flit 2 with src_router=1 after flit 0 with src_router=0 -> seq_error pulse, with no dfx_valid.
REQ-045 SHALL cover rst_n low after flit 2 -> all outputs 0, decode_ready=1, and a subsequent sequence 0..4 decoding correctly.
